// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix multiply block and its MAC sequencer.
package matrix_pkg;

  localparam int N_DEFAULT = 3;
  localparam int DATA_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/matrix_idx_counter.sv
// Nested i/j/k operand index counter: k steps inside an element, (i,j) steps row-major.
// One cycle from step/clear to updated index; no backpressure, the caller gates the steps.
module matrix_idx_counter #(
  parameter  int N     = 3,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             step_k_i,
  input  logic             step_ij_i,
  output logic [IDX_W-1:0] i_o,
  output logic [IDX_W-1:0] j_o,
  output logic [IDX_W-1:0] k_o,
  output logic             last_k_o,
  output logic             last_elem_o
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic [IDX_W-1:0] i_q, j_q, k_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (clear_i) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (step_ij_i) begin
      k_q <= '0;
      if (j_q == LAST) begin
        j_q <= '0;
        i_q <= (i_q == LAST) ? '0 : i_q + IDX_W'(1);
      end else begin
        j_q <= j_q + IDX_W'(1);
      end
    end else if (step_k_i) begin
      k_q <= k_q + IDX_W'(1);
    end
  end

  assign i_o         = i_q;
  assign j_o         = j_q;
  assign k_o         = k_q;
  assign last_k_o    = (k_q == LAST);
  assign last_elem_o = (i_q == LAST) && (j_q == LAST);

endmodule

// File: rtl/matrix_mac_sequencer.sv
// Control FSM sharing one MAC datapath across all N*N elements of C = A*B.
// Per element N+MAC_LAT+1 cycles; start is ignored while busy, no abort other than reset.
module matrix_mac_sequencer
  import matrix_pkg::*;
#(
  parameter  int N       = N_DEFAULT,
  parameter  int MAC_LAT = 1,
  localparam int IDX_W   = $clog2(N),
  localparam int WR_W    = $clog2(N * N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] row_idx,
  output logic [IDX_W-1:0] col_idx,
  output logic [IDX_W-1:0] k_idx,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             wr_en,
  output logic [WR_W-1:0]  wr_idx
);

  localparam logic [2:0] DRAIN_LAST = (MAC_LAT > 0) ? 3'(MAC_LAT - 1) : 3'd0;

  state_t          state_q, state_d;
  logic [2:0]      drain_q, drain_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            acc_en_q, acc_en_d;
  logic            acc_clr_q, acc_clr_d;
  logic            wr_en_q, wr_en_d;
  logic [WR_W-1:0] wr_idx_q, wr_idx_d;
  logic            idx_clear, step_k, step_ij;
  logic            last_k, last_elem;

  matrix_idx_counter #(.N(N)) u_idx (
    .clk_i       (clk),
    .rst_ni      (reset),
    .clear_i     (idx_clear),
    .step_k_i    (step_k),
    .step_ij_i   (step_ij),
    .i_o         (row_idx),
    .j_o         (col_idx),
    .k_o         (k_idx),
    .last_k_o    (last_k),
    .last_elem_o (last_elem)
  );

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    idx_clear = 1'b0;
    step_k    = 1'b0;
    step_ij   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = MAC;
          idx_clear = 1'b1;
        end
      end
      MAC: begin
        if (last_k) begin
          if (MAC_LAT > 0) begin
            state_d = DRAIN;
            drain_d = DRAIN_LAST;
          end else begin
            state_d = WRITE;
          end
        end else begin
          step_k = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == 3'd0) state_d = WRITE;
        else                 drain_d = drain_q - 3'd1;
      end
      WRITE: begin
        step_ij = 1'b1;
        state_d = last_elem ? DONE : MAC;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it;
    // indices only advance after WRITE, so row/col still name the written element.
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    acc_en_d  = (state_d == MAC);
    acc_clr_d = (state_d == MAC) && (state_q != MAC);
    wr_en_d   = (state_d == WRITE);
    wr_idx_d  = (state_d == WRITE) ? WR_W'(int'(row_idx) * N + int'(col_idx)) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      drain_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      acc_en_q  <= acc_en_d;
      acc_clr_q <= acc_clr_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign acc_en  = acc_en_q;
  assign acc_clr = acc_clr_q;
  assign wr_en   = wr_en_q;
  assign wr_idx  = wr_idx_q;

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Bench for matrix_mac_sequencer: schedule checks at MAC_LAT 1/0/3 plus a MAC/regfile scoreboard.
module tb_matrix_mac_sequencer;
  import matrix_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start;
  logic       busy [3], done [3], acc_clr [3], acc_en [3], wr_en [3];
  logic [1:0] row_idx [3], col_idx [3], k_idx [3];
  logic [3:0] wr_idx [3];

  int n_pass   = 0;
  int n_checks = 0;
  int lat_of [3] = '{1, 0, 3};

  matrix_mac_sequencer #(.N(3), .MAC_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .start(start), .busy(busy[0]), .done(done[0]),
    .row_idx(row_idx[0]), .col_idx(col_idx[0]), .k_idx(k_idx[0]), .acc_clr(acc_clr[0]),
    .acc_en(acc_en[0]), .wr_en(wr_en[0]), .wr_idx(wr_idx[0]));
  matrix_mac_sequencer #(.N(3), .MAC_LAT(0)) u_lat0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy[1]), .done(done[1]),
    .row_idx(row_idx[1]), .col_idx(col_idx[1]), .k_idx(k_idx[1]), .acc_clr(acc_clr[1]),
    .acc_en(acc_en[1]), .wr_en(wr_en[1]), .wr_idx(wr_idx[1]));
  matrix_mac_sequencer #(.N(3), .MAC_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .start(start), .busy(busy[2]), .done(done[2]),
    .row_idx(row_idx[2]), .col_idx(col_idx[2]), .k_idx(k_idx[2]), .acc_clr(acc_clr[2]),
    .acc_en(acc_en[2]), .wr_en(wr_en[2]), .wr_idx(wr_idx[2]));

  // Shared MAC datapath and result register file driven by the MAC_LAT=1 sequencer.
  logic [DATA_W-1:0] mat_a [9];
  logic [DATA_W-1:0] mat_b [9];
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] c_mem [9];

  always_ff @(posedge clk) begin
    if (acc_en[0])
      acc_q <= (acc_clr[0] ? '0 : acc_q) +
               DATA_W'(mat_a[int'(row_idx[0]) * 3 + int'(k_idx[0])] *
                       mat_b[int'(k_idx[0]) * 3 + int'(col_idx[0])]);
    if (wr_en[0]) c_mem[wr_idx[0]] <= acc_q;
  end

  typedef struct {
    logic [DATA_W-1:0] a [9];
    logic [DATA_W-1:0] b [9];
    logic [DATA_W-1:0] c [9];
  } vec_t;
  vec_t vecs [3];

  typedef struct {
    int idx;
    int val;
  } exp_t;
  exp_t sb [$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pack_out(input int d);
    return int'({busy[d], done[d], acc_en[d], acc_clr[d], wr_en[d], wr_idx[d],
                 row_idx[d], col_idx[d], k_idx[d]});
  endfunction

  // Expected outputs in cycle cyc of a run (cycle 1 follows the edge that samples start).
  function automatic int exp_sched(input int cyc, input int lat);
    int p, last, e, ph;
    logic b, dn, ae, ac, we;
    logic [3:0] wi;
    logic [1:0] r, c, k;
    p = lat + 4;
    last = 9 * p;
    b = 0; dn = 0; ae = 0; ac = 0; we = 0; wi = 0; r = 0; c = 0; k = 0;
    if (cyc >= 1 && cyc <= last) begin
      e  = (cyc - 1) / p;
      ph = (cyc - 1) % p;
      b  = 1;
      r  = 2'(e / 3);
      c  = 2'(e % 3);
      ae = (ph < 3);
      ac = (ph == 0);
      k  = (ph < 3) ? 2'(ph) : 2'd2;
      if (ph == p - 1) begin
        we = 1;
        wi = 4'(e);
      end
    end else if (cyc == last + 1) begin
      b  = 1;
      dn = 1;
    end
    return int'({b, dn, ae, ac, we, wi, r, c, k});
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    repeat (3) step();
    for (int d = 0; d < 3; d++) check($sformatf("reset_state lat%0d", lat_of[d]), pack_out(d), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_vec(input int v);
    bit got_done;
    exp_t e;
    for (int x = 0; x < 9; x++) begin
      mat_a[x] = vecs[v].a[x];
      mat_b[x] = vecs[v].b[x];
      e.idx = x;
      e.val = int'(vecs[v].c[x]);
      sb.push_back(e);
    end
    got_done = 0;
    start = 1'b1;
    for (int c = 1; c <= 60 && !got_done; c++) begin
      step();
      start = 1'b0;
      if (wr_en[0]) begin
        check($sformatf("sb_nonempty v%0d", v), int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check($sformatf("sb_idx v%0d", v), int'(wr_idx[0]), e.idx);
          check($sformatf("sb_val v%0d e%0d", v, e.idx), int'(acc_q), e.val);
        end
      end
      if (done[0]) got_done = 1;
    end
    check($sformatf("run_done v%0d", v), int'(got_done), 1);
    check($sformatf("sb_empty v%0d", v), sb.size(), 0);
    for (int x = 0; x < 9; x++)
      check($sformatf("cmem v%0d e%0d", v, x), int'(c_mem[x]), int'(vecs[v].c[x]));
    sb.delete();
    repeat (2) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0].a = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    vecs[0].b = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    vecs[0].c = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    vecs[1].a = '{default: 2};
    vecs[1].b = '{default: 3};
    vecs[1].c = '{default: 18};
    vecs[2].a = '{default: 255};
    vecs[2].b = '{default: 1};
    vecs[2].c = '{default: 253};

    // Single start: full schedule for MAC_LAT 1, 0 and 3 side by side.
    do_reset();
    start = 1'b1;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      step();
      start = 1'b0;
      for (int d = 0; d < 3; d++)
        check($sformatf("sched lat%0d c%0d", lat_of[d], cyc), pack_out(d), exp_sched(cyc, lat_of[d]));
    end

    for (int v = 0; v < 3; v++) run_vec(v);

    // Stray start pulses during the run (and in DONE) must not perturb or restart it.
    start = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      step();
      check($sformatf("stray_start c%0d", cyc), pack_out(0), exp_sched(cyc, 1));
      start = (cyc == 3 || cyc == 20 || cyc == 46) ? 1'b1 : 1'b0;
    end

    // start held high: one IDLE cycle between done and the next run.
    start = 1'b1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      step();
      if (cyc <= 46) check($sformatf("held c%0d", cyc), pack_out(0), exp_sched(cyc, 1));
      else if (cyc == 47) check("held idle gap", pack_out(0), 0);
      else check($sformatf("held c%0d", cyc), pack_out(0), exp_sched(cyc - 47, 1));
      if (cyc == 93) start = 1'b0;
    end

    // Asynchronous reset in the DRAIN cycle of element 4.
    start = 1'b1;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      step();
      start = 1'b0;
    end
    check("pre_reset drain e4", pack_out(0), exp_sched(24, 1));
    #2;
    reset = 1'b0;
    #1;
    check("async_reset outputs", pack_out(0), 0);
    for (int r = 0; r < 3; r++) begin
      step();
      check($sformatf("reset_hold %0d", r), pack_out(0), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
    run_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/matrix_mac_sequencer.md
Name: matrix_mac_sequencer

Overview:
Control FSM that time-multiplexes one shared multiply-accumulate (MAC) datapath across all N×N elements of C = A·B. It operates on the same 3×3, 8-bit operand set as the Matrix block.
- Generates operand-select indices (i, k, j), accumulator clear/enable, and result-write strobes.
- Waits out the datapath's accumulate latency before each write.
- Reports busy/done to the host.
- Control only: no arithmetic is performed here.

Parameters:
N, 3, matrix dimension (N ≥ 2)
MAC_LAT, 1, cycles from acc_en to the accumulator holding the updated sum (0..7)
IDX_W, $clog2(N), localparam: width of row/col/k indices
WR_W, $clog2(N*N), localparam: width of the write index

Ports:
clk  in  1  single clock; all logic rising-edge.
reset  in  1  asynchronous, active-low reset (assert at 0, release synchronously to clk).
start  in  1  begin a multiply; sampled only in IDLE.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse after the last result write.
row_idx  out  IDX_W  i: selects A row / C row.
col_idx  out  IDX_W  j: selects B column / C column.
k_idx  out  IDX_W  k: selects A column and B row.
acc_clr  out  1  with acc_en, load the product instead of adding.
acc_en  out  1  accumulate a[i][k]*b[k][j] this cycle.
wr_en  out  1  write the accumulator into C[i][j].
wr_idx  out  WR_W  i*N+j, valid while wr_en is high, else 0.

Behaviour:
- States: IDLE, MAC, DRAIN, WRITE, DONE. Moore outputs, all registered.
- Reset (reset=0, any time, including mid-operation):
  - State goes to IDLE immediately.
  - i, j, k are 0.
  - All outputs are 0.
  - No wr_en is issued during or after reset.
- IDLE: if start=1, go to MAC with i=j=k=0. Otherwise remain in IDLE.
- MAC: runs N consecutive cycles, k = 0..N-1.
  - acc_en=1 on every MAC cycle.
  - acc_clr=1 only when k=0.
  - After k=N-1: go to DRAIN if MAC_LAT>0, else go to WRITE.
- DRAIN: runs MAC_LAT cycles with acc_en=0. Indices are held. Then go to WRITE.
- WRITE: lasts 1 cycle.
  - wr_en=1, wr_idx=i*N+j. row_idx/col_idx still show the written element.
  - Advance indices: j+1; if j=N-1, then j=0 and i+1. k resets to 0.
  - If the written element was (N-1, N-1), go to DONE; else go to MAC.
- DONE: lasts 1 cycle with done=1 and busy=1. Then go to IDLE.
- Latency:
  - Per element: N+MAC_LAT+1 cycles.
  - With start sampled at edge 0, the final WRITE is in cycle N²(N+MAC_LAT+1) and done is in the following cycle.
  - Defaults (N=3, MAC_LAT=1): writes in cycles 5, 10, …, 45; done in cycle 46.
- start while busy (including in DONE): ignored. No restart, no abort.
- start held high continuously: the next run begins on the first cycle after DONE, i.e. the FSM spends exactly one cycle in IDLE.
- Indices never exceed N-1. Elements are written in row-major order, each exactly once per run.
- Output widths come from the localparams. The N=3 defaults give 2-bit indices and a 4-bit wr_idx.

Decomposition:
- Package matrix_pkg:
  - State enum (IDLE, MAC, DRAIN, WRITE, DONE).
  - Default N and the 8-bit data-width constant shared with the datapath.
- Sub-module matrix_idx_counter: nested i/j/k counter with clear, step_k, and step_ij inputs, plus last_k and last_elem flags.
- The FSM and the DRAIN down-counter stay in matrix_mac_sequencer.

Test Plan:
1. Reset, then a single start pulse (N=3, MAC_LAT=1):
   - wr_en pulses in cycles 5, 10, …, 45 with wr_idx 0..8 in order.
   - done is high only in cycle 46; busy is high in cycles 1..46.
2. Drive a shared MAC plus register file from the sequencer:
   - A = [1 2 3; 4 5 6; 7 8 9], B = I → C = A.
   - A = all-2, B = all-3 → every C element is 18.
   - A = all-255, B = all-1 → 765 mod 256 = 253 in every element.
3. Pulse start at cycles 3, 20, and 46 during a run → no timing perturbation. After done, a new run begins only on a fresh start sampled in IDLE.
4. start held at 1 → back-to-back runs with exactly one IDLE cycle between done and the next acc_en.
5. Assert reset=0 asynchronously mid-DRAIN of element 4:
   - All outputs go to 0 immediately, with no wr_en.
   - After release, a fresh start writes from wr_idx 0.
6. MAC_LAT=0 → no DRAIN; writes occur every 4 cycles, done in cycle 37. MAC_LAT=3 → per-element period of 7 cycles, done in cycle 64.
